// File: rtl/multi_pattern_generator.sv
// multi_pattern_generator
// Streams synthetic test frames into the 17-bit pixel queue of the frame-buffer
// loader. Word format: bit16 = marker flag, bits15:0 = pixel (RGB565) or marker code.
// Markers: 0x10000 frame start, 0x10001 row start, 0x1FFFF frame end.
// Patterns (latched at frame start): 0 colour bars, 1 gradient, 2 checkerboard, 3 solid.
//
// Ports:
//   clk_i           system clock
//   reset_i         synchronous, active-high reset
//   enable_i        starts a new frame from IDLE while high
//   mode_i[1:0]     pattern select
//   solid_color_i   RGB565 colour for mode 3
//   queue_full_i    queue almost-full; no word is issued on an edge where it is high
//   queue_data_o    registered queue word
//   queue_wr_en_o   registered write strobe, one word per high cycle
//   frame_done_o    one-cycle pulse alongside the frame-end marker
//   frame_count_o   completed frames, wraps
//
// Optional build macro PATTERN_SCROLL_EN: adds a per-frame column offset so
// modes 0-2 scroll left one pixel per frame.
//
// state        | meaning
// S_IDLE       | no output; waits for enable_i
// S_FRAME_START| issue frame-start marker, latch mode and solid colour
// S_ROW_START  | issue row-start marker, clear column and bar counters
// S_PIXELS     | issue FRAME_WIDTH pixel words of the current row
// S_FRAME_END  | issue frame-end marker, pulse frame_done, bump frame counter
module multi_pattern_generator #(
    parameter int FRAME_WIDTH    = 480,
    parameter int FRAME_HEIGHT   = 272,
    parameter int NUM_COLOR_BARS = 10,
    parameter int CHECKER_SHIFT  = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic [1:0]  mode_i,
    input  logic [15:0] solid_color_i,
    input  logic        queue_full_i,
    output logic [16:0] queue_data_o,
    output logic        queue_wr_en_o,
    output logic        frame_done_o,
    output logic [15:0] frame_count_o
);

    localparam int          BW       = FRAME_WIDTH / NUM_COLOR_BARS;
    localparam logic [10:0] LAST_COL = 11'(FRAME_WIDTH - 1);
    localparam logic [10:0] LAST_ROW = 11'(FRAME_HEIGHT - 1);
    localparam logic [10:0] BW_LAST  = 11'(BW - 1);
    localparam logic [3:0]  BAR_LAST = 4'(NUM_COLOR_BARS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FRAME_START, S_ROW_START, S_PIXELS, S_FRAME_END
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] col_q, col_d, row_q, row_d, sub_q, sub_d;
    logic [3:0]  bar_q, bar_d;
    logic [1:0]  mode_q, mode_d;
    logic [15:0] solid_q, solid_d, count_q, count_d;
    logic [16:0] data_q, data_d;
    logic        wr_en_q, wr_en_d, done_q, done_d;
    logic [10:0] ccol;
    logic [15:0] pixel;
    logic [3:0]  seed_bar;
    logic [10:0] seed_sub;

    // Bar counter step: the bar index advances every BW columns and sticks at
    // the last bar so remainder columns reuse it.
    function automatic logic [14:0] bar_step(input logic [3:0] b, input logic [10:0] s);
        if (s == BW_LAST)
            return {(b == BAR_LAST) ? b : b + 4'd1, 11'd0};
        return {b, s + 11'd1};
    endfunction

    function automatic logic [15:0] bar_color(input logic [3:0] idx);
        case (idx)
            4'd0:    return 16'h6B4D;
            4'd1:    return 16'hB5B6;
            4'd2:    return 16'hB5A2;
            4'd3:    return 16'h15B6;
            4'd4:    return 16'h15A2;
            4'd5:    return 16'hB096;
            4'd6:    return 16'hB082;
            4'd7:    return 16'h1096;
            4'd8:    return 16'h1082;
            default: return 16'hEF5D;
        endcase
    endfunction

`ifdef PATTERN_SCROLL_EN
    logic [10:0] offset_q, offset_d, seed_sub_q, seed_sub_d;
    logic [3:0]  seed_bar_q, seed_bar_d;
    logic [11:0] csum;

    // Colour column = (col + offset) mod FRAME_WIDTH; both terms are below
    // FRAME_WIDTH so one conditional subtract suffices.
    assign csum     = {1'b0, col_q} + {1'b0, offset_q};
    assign ccol     = (csum >= 12'(FRAME_WIDTH)) ? 11'(csum - 12'(FRAME_WIDTH)) : csum[10:0];
    assign seed_bar = seed_bar_q;
    assign seed_sub = seed_sub_q;
`else
    assign ccol     = col_q;
    assign seed_bar = 4'd0;
    assign seed_sub = 11'd0;
`endif

    always_comb begin
        pixel = solid_q;
        case (mode_q)
            2'd0: pixel = bar_color(bar_q);
            2'd1: pixel = {ccol[4:0], row_q[5:0], 5'(ccol[4:0] + row_q[4:0])};
            2'd2: pixel = (ccol[CHECKER_SHIFT] ^ row_q[CHECKER_SHIFT]) ? 16'hFFFF : 16'h0000;
            default: pixel = solid_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        bar_d   = bar_q;
        sub_d   = sub_q;
        mode_d  = mode_q;
        solid_d = solid_q;
        count_d = count_q;
        data_d  = data_q;
        wr_en_d = 1'b0;
        done_d  = 1'b0;
`ifdef PATTERN_SCROLL_EN
        offset_d   = offset_q;
        seed_bar_d = seed_bar_q;
        seed_sub_d = seed_sub_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (enable_i) state_d = S_FRAME_START;
            end
            S_FRAME_START: begin
                if (!queue_full_i) begin
                    data_d  = 17'h10000;
                    wr_en_d = 1'b1;
                    mode_d  = mode_i;
                    solid_d = solid_color_i;
                    row_d   = 11'd0;
                    state_d = S_ROW_START;
                end
            end
            S_ROW_START: begin
                if (!queue_full_i) begin
                    data_d  = 17'h10001;
                    wr_en_d = 1'b1;
                    col_d   = 11'd0;
                    bar_d   = seed_bar;
                    sub_d   = seed_sub;
                    state_d = S_PIXELS;
                end
            end
            S_PIXELS: begin
                if (!queue_full_i) begin
                    data_d  = {1'b0, pixel};
                    wr_en_d = 1'b1;
                    col_d   = col_q + 11'd1;
                    // Colour column wrapping back to 0 restarts the bars.
                    if (ccol == LAST_COL) {bar_d, sub_d} = 15'd0;
                    else                  {bar_d, sub_d} = bar_step(bar_q, sub_q);
                    if (col_q == LAST_COL) begin
                        if (row_q == LAST_ROW) begin
                            state_d = S_FRAME_END;
                        end else begin
                            row_d   = row_q + 11'd1;
                            state_d = S_ROW_START;
                        end
                    end
                end
            end
            S_FRAME_END: begin
                if (!queue_full_i) begin
                    data_d  = 17'h1FFFF;
                    wr_en_d = 1'b1;
                    done_d  = 1'b1;
                    count_d = count_q + 16'd1;
                    state_d = S_IDLE;
`ifdef PATTERN_SCROLL_EN
                    // Seeds track the bar position of colour column == offset.
                    if (offset_q == LAST_COL) begin
                        offset_d                 = 11'd0;
                        {seed_bar_d, seed_sub_d} = 15'd0;
                    end else begin
                        offset_d                 = offset_q + 11'd1;
                        {seed_bar_d, seed_sub_d} = bar_step(seed_bar_q, seed_sub_q);
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            bar_q   <= '0;
            sub_q   <= '0;
            mode_q  <= '0;
            solid_q <= '0;
            count_q <= '0;
            data_q  <= '0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef PATTERN_SCROLL_EN
            offset_q   <= '0;
            seed_bar_q <= '0;
            seed_sub_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            bar_q   <= bar_d;
            sub_q   <= sub_d;
            mode_q  <= mode_d;
            solid_q <= solid_d;
            count_q <= count_d;
            data_q  <= data_d;
            wr_en_q <= wr_en_d;
            done_q  <= done_d;
`ifdef PATTERN_SCROLL_EN
            offset_q   <= offset_d;
            seed_bar_q <= seed_bar_d;
            seed_sub_q <= seed_sub_d;
`endif
        end
    end

    assign queue_data_o  = data_q;
    assign queue_wr_en_o = wr_en_q;
    assign frame_done_o  = done_q;
    assign frame_count_o = count_q;

endmodule
